jtcop_mixn: RTL and testbench
=============================

Name: jtcop_mixn

Overview:
- Parametrised N-layer colour mixer. It is the next-generation replacement for the fixed 3-background + object mixer in the video top.
- It takes LAYERS pixel streams and uses a CPU-loadable priority table to select a winning layer per pixel.
- The winning pixel is looked up in a CPU-writable palette, and the block outputs 8-bit RGB plus delayed blanking.
- It sits between the tile/object layer engines and the video output.

Parameters:
LAYERS, 4, number of input layers (2..8); layer 0 on bit 0 of every packed bus
PXLW, 8, bits per layer pixel; [3:0] = colour index, [PXLW-1:4] = palette bank
LW, $clog2(LAYERS), width of winning-layer index (derived, not overridable)
PALW, LW+PXLW, palette word address width (derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
pxl_cen  in  1  pixel clock enable
LHBL  in  1  horizontal blank, active-low, aligned with layer pixels
LVBL  in  1  vertical blank, active-low, aligned with layer pixels
pxl  in  LAYERS*PXLW  packed layer pixels
gfx_en  in  LAYERS  debug per-layer enable; 0 forces layer transparent
prisel  in  3  priority table page select
cpu_addr  in  PALW  palette word address
cpu_dout  in  16  CPU write data
cpu_dsn  in  2  byte strobes, active-low ([1]=upper)
pal_cs  in  1  palette select; write when pal_cs & ~cpu_rnw
cpu_rnw  in  1  CPU read/not-write
pal_dout  out  16  palette read data
prog_addr  in  3+LAYERS  priority table write address {page, opaque mask}
prom_din  in  LW  priority table data (winning layer index)
prom_we  in  1  priority table write strobe
red, green, blue  out  8 each  output colour
LHBL_dly, LVBL_dly  out  1 each  blanking delayed to match colour

Behaviour:
- Reset (rst low, asynchronous): red/green/blue = 0, LHBL_dly = LVBL_dly = 0, pal_dout = 0, all pipeline registers = 0.
- Table and palette RAM contents are not cleared by reset.
- The pipeline advances only on clk edges with pxl_cen = 1. Latency is 5 pxl_cen ticks from pxl/LHBL/LVBL to the outputs.
- S1: register pxl, prisel, LHBL, LVBL.
  - opaque[i] = gfx_en[i] & (pxl_i[3:0] != 0).
- S2: priority table read at {prisel, opaque}, giving win index w (LW bits).
  - An out-of-range w (w >= LAYERS) is treated as layer 0.
- S3: palette address = {w, pxl_w}.
  - All layers transparent: the table entry still applies, and index 0 of that layer's bank is used (the backdrop).
- S4: synchronous palette read of a 16-bit word in {4'x, B[3:0], G[3:0], R[3:0]} format.
- S5: expand each nibble n to {n, n}.
  - If the S5-aligned LHBL & LVBL = 0, the colour outputs are 0.
  - LHBL_dly/LVBL_dly are S5 copies of the inputs.
- Priority table: 2^(3+LAYERS) x LW bits. Written when prom_we = 1, independent of pxl_cen. A write takes effect on the next S2 read.
- Palette: 2^PALW x 16 bits, true dual-port.
  - CPU port: byte writes per cpu_dsn.
  - pal_dout is registered and equals mem[cpu_addr] one clk after the address is presented.
  - Video port: read-before-write. On a same-cycle collision with a CPU write to the same address, the video port gets the old data.
- Blanking is applied only at S5. The palette is always read, so there is no stall.
- pxl_cen held low: all outputs hold. No internal state changes except CPU/table writes.
- Reset mid-line: the pipeline is flushed. Outputs stay 0 until 5 valid ticks after reset release.

Optional Feature:
- Macro: JTCOP_MIX_SHADOW_EN.
- Enabled:
  - Adds input port shadow (1 bit), aligned with pxl and registered at S1.
  - When the S5-aligned shadow = 1 and the winning layer is not LAYERS-1, each output channel is the expanded value shifted right by 1 (e.g. 8'hFF -> 8'h7F).
- Disabled:
  - No shadow port and no dimming logic.
  - Latency is identical (5 ticks).

Test Plan:
1. Reset: hold rst low, toggle clk with pxl_cen = 1 -> all outputs are 0. After release with LHBL = LVBL = 1, colour is 0 until the 5th pxl_cen tick.
2. Priority: LAYERS = 4; table[{0, 4'b0101}] = 2; layers 0 and 2 opaque, layer 2 = 8'h13; palette[{2, 8'h13}] = 16'h0A5F -> 5 ticks later red = FF, green = 55, blue = AA.
3. gfx_en: same stimulus as test 2 with gfx_en[2] = 0, table[{0, 4'b0001}] = 0, layer 0 = 8'h01, palette[{0, 8'h01}] = 16'h0123 -> red = 33, green = 22, blue = 11.
4. Blanking: LHBL = 0 for one pixel -> LHBL_dly low exactly 5 ticks later, with colour 0 on that pixel only.
5. CPU palette: write 16'h1234 to address 10'h3FF with cpu_dsn = 2'b01 over a prior 16'hFFFF -> read-back 16'h12FF. A collision write while video reads the same address -> video sees the old value.
6. Shadow (macro on): test 2 stimulus plus shadow = 1 -> red = 7F, green = 2A, blue = 55. With w = 3 the colour is undimmed.

Source files
------------

// File: rtl/jtcop_mixn_if.sv
// CPU palette bus for jtcop_mixn.
//   master : CPU side, drives address/data/strobes, receives pal_dout
//   slave  : mixer side
// cpu_dsn is active-low byte strobes ([1] = upper byte); a write happens
// when pal_cs & ~cpu_rnw.
interface jtcop_mixn_if #(parameter int PALW = 10);
  logic [PALW-1:0] cpu_addr;
  logic [15:0]     cpu_dout;
  logic [1:0]      cpu_dsn;
  logic            pal_cs;
  logic            cpu_rnw;
  logic [15:0]     pal_dout;

  modport master(output cpu_addr, cpu_dout, cpu_dsn, pal_cs, cpu_rnw, input pal_dout);
  modport slave (input  cpu_addr, cpu_dout, cpu_dsn, pal_cs, cpu_rnw, output pal_dout);
endinterface

// File: rtl/jtcop_mixn.sv
// jtcop_mixn: N-layer colour mixer.
// Each pixel, the opaque mask of LAYERS input layers (plus a 3-bit page)
// indexes a CPU-loaded priority table that names the winning layer. The
// winner's pixel {layer, bank, colour} addresses a 16-bit palette word
// {4'x, B, G, R} whose nibbles are expanded to 8-bit RGB.
// Five pxl_cen ticks from pxl/LHBL/LVBL to red/green/blue/LHBL_dly/LVBL_dly.
//
// Ports:
//   clk, rst (async, active-low), pxl_cen  clocking
//   LHBL, LVBL                             blanking in, aligned with pxl
//   pxl                                    packed layer pixels, layer 0 at LSB
//   gfx_en                                 per-layer debug enable
//   prisel                                 priority table page
//   bus                                    CPU palette port (jtcop_mixn_if.slave)
//   prog_addr, prom_din, prom_we           priority table load port
//   shadow                                 dimming request (only with macro)
//   red, green, blue, LHBL_dly, LVBL_dly   video out
//
// Optional: define JTCOP_MIX_SHADOW_EN to add the shadow input, which halves
// the colour of any pixel not won by the top layer (LAYERS-1).
module jtcop_mixn #(
  parameter  int LAYERS = 4,
  parameter  int PXLW   = 8,
  localparam int LW     = $clog2(LAYERS),
  localparam int PALW   = LW + PXLW
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pxl_cen,
  input  logic                     LHBL,
  input  logic                     LVBL,
  input  logic [LAYERS*PXLW-1:0]   pxl,
  input  logic [LAYERS-1:0]        gfx_en,
  input  logic [2:0]               prisel,
  jtcop_mixn_if.slave              bus,
  input  logic [2+LAYERS:0]        prog_addr,
  input  logic [LW-1:0]            prom_din,
  input  logic                     prom_we,
`ifdef JTCOP_MIX_SHADOW_EN
  input  logic                     shadow,
`endif
  output logic [7:0]               red,
  output logic [7:0]               green,
  output logic [7:0]               blue,
  output logic                     LHBL_dly,
  output logic                     LVBL_dly
);
  // stages ahead of the output register (S1..S4)
  localparam int STAGES = 4;

  logic [STAGES-1:0]             vld_pipe;
  logic [STAGES-1:0]             hb_pipe, vb_pipe;
  logic [LAYERS-1:0][PXLW-1:0]   pxl1, pxl2;
  logic [LAYERS-1:0]             opaque1;
  logic [2:0]                    prisel1;
  logic [LW-1:0]                 w2;
  logic [PALW-1:0]               addr3;
  logic [15:0]                   vid4;
  logic [LW-1:0]                 tbl_rd;
  logic                          pal_we;
  logic                          dim;

  logic [LW-1:0] ptbl [2**(3+LAYERS)];
  logic [15:0]   pal  [2**PALW];

  function automatic logic [7:0] expand(input logic [3:0] n, input logic half);
    expand = half ? {1'b0, n, n[3:1]} : {n, n};
  endfunction

  // priority table load runs at full clk rate
  always_ff @(posedge clk)
    if (prom_we) ptbl[prog_addr] <= prom_din;

  // CPU palette port: byte writes, registered read
  assign pal_we = bus.pal_cs & ~bus.cpu_rnw;

  always_ff @(posedge clk) begin
    if (pal_we & ~bus.cpu_dsn[0]) pal[bus.cpu_addr][7:0]  <= bus.cpu_dout[7:0];
    if (pal_we & ~bus.cpu_dsn[1]) pal[bus.cpu_addr][15:8] <= bus.cpu_dout[15:8];
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.pal_dout <= '0;
    else      bus.pal_dout <= pal[bus.cpu_addr];

  assign tbl_rd = ptbl[{prisel1, opaque1}];

`ifdef JTCOP_MIX_SHADOW_EN
  logic [STAGES-1:0] sh_pipe;
  logic [LW-1:0]     w3, w4;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sh_pipe <= '0;
      w3      <= '0;
      w4      <= '0;
    end else if (pxl_cen) begin
      sh_pipe <= {sh_pipe[STAGES-2:0], shadow};
      w3      <= w2;
      w4      <= w3;
    end

  assign dim = sh_pipe[STAGES-1] & (w4 != LW'(LAYERS-1));
`else
  assign dim = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      hb_pipe  <= '0;
      vb_pipe  <= '0;
      pxl1     <= '0;
      pxl2     <= '0;
      opaque1  <= '0;
      prisel1  <= '0;
      w2       <= '0;
      addr3    <= '0;
      vid4     <= '0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], 1'b1};
      hb_pipe  <= {hb_pipe[STAGES-2:0], LHBL};
      vb_pipe  <= {vb_pipe[STAGES-2:0], LVBL};
      // S1
      pxl1    <= pxl;
      prisel1 <= prisel;
      for (int i = 0; i < LAYERS; i++)
        opaque1[i] <= gfx_en[i] & (pxl[i*PXLW +: 4] != 4'd0);
      // S2: entries naming a non-existent layer fall back to layer 0
      pxl2 <= pxl1;
      w2   <= (int'(tbl_rd) >= LAYERS) ? '0 : tbl_rd;
      // S3: a transparent winner has colour 0, which lands on its bank backdrop
      addr3 <= {w2, pxl2[w2]};
      // S4: video port reads before any same-edge CPU write lands
      vid4 <= pal[addr3];
      // S5
      LHBL_dly <= hb_pipe[STAGES-1];
      LVBL_dly <= vb_pipe[STAGES-1];
      if (vld_pipe[STAGES-1] & hb_pipe[STAGES-1] & vb_pipe[STAGES-1]) begin
        red   <= expand(vid4[3:0],  dim);
        green <= expand(vid4[7:4],  dim);
        blue  <= expand(vid4[11:8], dim);
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_jtcop_mixn.sv
module tb_jtcop_mixn;
  localparam int LAYERS = 4;
  localparam int PXLW   = 8;
  localparam int LW     = 2;
  localparam int PALW   = LW + PXLW;

  typedef struct packed {
    logic [LAYERS*PXLW-1:0] pxl;
    logic [LAYERS-1:0]      gfx;
    logic [2:0]             prisel;
    logic                   hb, vb, sh;
  } vec_t;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       hd, vd;
  } exp_t;

  typedef struct packed {
    vec_t v;
    exp_t e;
  } dir_t;

  logic clk = 0, rst = 0, pxl_cen = 0, LHBL = 0, LVBL = 0;
  logic [LAYERS*PXLW-1:0] pxl = '0;
  logic [LAYERS-1:0]      gfx_en = '1;
  logic [2:0]             prisel = '0;
  logic [2+LAYERS:0]      prog_addr = '0;
  logic [LW-1:0]          prom_din = '0;
  logic                   prom_we = 0;
`ifdef JTCOP_MIX_SHADOW_EN
  logic                   shadow = 0;
`endif
  logic [7:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  jtcop_mixn_if #(.PALW(PALW)) bus();

  jtcop_mixn #(.LAYERS(LAYERS), .PXLW(PXLW)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .pxl(pxl), .gfx_en(gfx_en), .prisel(prisel), .bus(bus),
    .prog_addr(prog_addr), .prom_din(prom_din), .prom_we(prom_we),
`ifdef JTCOP_MIX_SHADOW_EN
    .shadow(shadow),
`endif
    .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: end not reached, limit 200000 time units");
    $fatal(1, "timeout");
  end

  // reference state: what the CPU has loaded
  logic [LW-1:0] tbl_m [2**(3+LAYERS)];
  logic [15:0]   pal_m [2**PALW];

  int   checks = 0, errors = 0;
  exp_t q[$];
  exp_t last = '0;
  dir_t dirs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic cmp_out(string tag, exp_t e);
    chk({tag, ".red"},      red,      e.r);
    chk({tag, ".green"},    green,    e.g);
    chk({tag, ".blue"},     blue,     e.b);
    chk({tag, ".LHBL_dly"}, LHBL_dly, e.hd);
    chk({tag, ".LVBL_dly"}, LVBL_dly, e.vd);
  endtask

  // what the spec says the pixel should look like, from the loaded tables
  function automatic exp_t model(vec_t v);
    exp_t e;
    logic [LAYERS-1:0] m;
    logic [PXLW-1:0]   p;
    logic [15:0]       d;
    int w, sh;
    for (int i = 0; i < LAYERS; i++) m[i] = v.gfx[i] && (v.pxl[i*PXLW +: 4] != 0);
    w = int'(tbl_m[{v.prisel, m}]);
    if (w >= LAYERS) w = 0;
    p = v.pxl[w*PXLW +: PXLW];
    d = pal_m[w * (2**PXLW) + int'(p)];
    sh = 0;
`ifdef JTCOP_MIX_SHADOW_EN
    if (v.sh && w != LAYERS-1) sh = 1;
`endif
    e.r  = 8'((int'(d[3:0])  * 17) >> sh);
    e.g  = 8'((int'(d[7:4])  * 17) >> sh);
    e.b  = 8'((int'(d[11:8]) * 17) >> sh);
    e.hd = v.hb;
    e.vd = v.vb;
    if (!(v.hb && v.vb)) begin e.r = 0; e.g = 0; e.b = 0; end
    return e;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < LAYERS; i++) begin
      v.pxl[i*PXLW +: PXLW] = PXLW'($urandom);
      if ($urandom_range(1, 0) == 0) v.pxl[i*PXLW +: 4] = 4'd0;
    end
    v.gfx    = ($urandom_range(3, 0) == 0) ? LAYERS'($urandom) : '1;
    v.prisel = 3'($urandom);
    v.hb     = ($urandom_range(7, 0) != 0);
    v.vb     = ($urandom_range(15, 0) != 0);
    v.sh     = 1'($urandom);
    return v;
  endfunction

  function automatic vec_t mk(logic [31:0] p, logic [3:0] g, logic hb, logic vb, logic sh);
    vec_t v;
    v.pxl = p; v.gfx = g; v.prisel = 3'd0; v.hb = hb; v.vb = vb; v.sh = sh;
    return v;
  endfunction

  function automatic exp_t mke(logic [7:0] r, logic [7:0] g, logic [7:0] b, logic hd, logic vd);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.hd = hd; e.vd = vd;
    return e;
  endfunction

  // one clk edge; on a pxl_cen tick the pixel enters the pipe and the
  // pixel captured four ticks earlier must show at the outputs
  task automatic tick(string tag, vec_t v, exp_t e, bit cen);
    pxl = v.pxl; gfx_en = v.gfx; prisel = v.prisel; LHBL = v.hb; LVBL = v.vb;
`ifdef JTCOP_MIX_SHADOW_EN
    shadow = v.sh;
`endif
    pxl_cen = cen;
    @(posedge clk); #1;
    if (cen) begin
      q.push_back(e);
      if (q.size() >= 5) last = q.pop_front();
      else               last = '0;
    end
    cmp_out(tag, last);
  endtask

  task automatic do_reset(string tag);
    rst = 0; pxl_cen = 1; LHBL = 1; LVBL = 1;
    repeat (3) @(posedge clk);
    #1;
    cmp_out(tag, '0);
    chk({tag, ".pal_dout"}, bus.pal_dout, 32'h0);
    rst = 1;
    q.delete();
    last = '0;
  endtask

  task automatic pal_wr(logic [PALW-1:0] a, logic [15:0] d, logic [1:0] dsn);
    bus.cpu_addr = a; bus.cpu_dout = d; bus.cpu_dsn = dsn; bus.pal_cs = 1; bus.cpu_rnw = 0;
    @(posedge clk); #1;
    bus.pal_cs = 0; bus.cpu_rnw = 1; bus.cpu_dsn = 2'b11;
    if (!dsn[0]) pal_m[a][7:0]  = d[7:0];
    if (!dsn[1]) pal_m[a][15:8] = d[15:8];
  endtask

  task automatic pal_rd(string name, logic [PALW-1:0] a, logic [15:0] req);
    bus.cpu_addr = a; bus.pal_cs = 1; bus.cpu_rnw = 1;
    @(posedge clk); #1;
    bus.pal_cs = 0;
    chk(name, bus.pal_dout, req);
  endtask

  task automatic tbl_wr(logic [2+LAYERS:0] a, logic [LW-1:0] d);
    prog_addr = a; prom_din = d; prom_we = 1;
    @(posedge clk); #1;
    prom_we = 0;
    tbl_m[a] = d;
  endtask

  initial begin
    vec_t t2, blank, v;
    logic [PALW-1:0] ra;

    bus.cpu_addr = '0; bus.cpu_dout = '0; bus.cpu_dsn = 2'b11;
    bus.pal_cs = 0; bus.cpu_rnw = 1;

    // reset state, clocked with pxl_cen high
    do_reset("reset0");

    // random table/palette contents, loaded with pxl_cen low
    pxl_cen = 0;
    for (int a = 0; a < 2**PALW; a++) pal_wr(PALW'(a), 16'($urandom), 2'b00);
    for (int a = 0; a < 2**(3+LAYERS); a++) tbl_wr((3+LAYERS)'(a), LW'($urandom));

    // directed table/palette entries
    tbl_wr({3'd0, 4'b0101}, 2'd2); pal_wr(10'h213, 16'h0A5F, 2'b00);
    tbl_wr({3'd0, 4'b0001}, 2'd0); pal_wr(10'h001, 16'h0123, 2'b00);
    tbl_wr({3'd0, 4'b0000}, 2'd3); pal_wr(10'h350, 16'h0ABC, 2'b00);
    tbl_wr({3'd0, 4'b1101}, 2'd3); pal_wr(10'h307, 16'h0F0F, 2'b00);

    // CPU byte writes and read-back
    pal_wr(10'h3FF, 16'hFFFF, 2'b00);
    pal_wr(10'h3FF, 16'h1234, 2'b01);
    pal_rd("cpu.upper_byte", 10'h3FF, 16'h12FF);
    pal_wr(10'h3FE, 16'hFFFF, 2'b00);
    pal_wr(10'h3FE, 16'h1234, 2'b10);
    pal_rd("cpu.lower_byte", 10'h3FE, 16'hFF34);
    pal_wr(10'h3FD, 16'h5678, 2'b11);
    pal_rd("cpu.no_strobe", 10'h3FD, pal_m[10'h3FD]);
    for (int i = 0; i < 6; i++) begin
      ra = PALW'($urandom);
      pal_rd($sformatf("cpu.rd%0d", i), ra, pal_m[ra]);
    end

    // memories survive reset
    do_reset("reset1");

    t2    = mk({8'h00, 8'h13, 8'h00, 8'h01}, 4'b1111, 1, 1, 0);
    blank = mk(32'h0, 4'b1111, 0, 0, 0);
    dirs.push_back({t2, mke(8'hFF, 8'h55, 8'hAA, 1, 1)});
    dirs.push_back({mk({8'h00, 8'h13, 8'h00, 8'h01}, 4'b1011, 1, 1, 0), mke(8'h33, 8'h22, 8'h11, 1, 1)});
    dirs.push_back({mk({8'h50, 8'h00, 8'h20, 8'h30}, 4'b1111, 1, 1, 0), mke(8'hCC, 8'hBB, 8'hAA, 1, 1)});
    dirs.push_back({t2, mke(8'hFF, 8'h55, 8'hAA, 1, 1)});
    dirs.push_back({mk({8'h00, 8'h13, 8'h00, 8'h01}, 4'b1111, 0, 1, 0), mke(8'h00, 8'h00, 8'h00, 0, 1)});
    dirs.push_back({t2, mke(8'hFF, 8'h55, 8'hAA, 1, 1)});
    dirs.push_back({mk({8'h00, 8'h13, 8'h00, 8'h01}, 4'b1111, 1, 0, 0), mke(8'h00, 8'h00, 8'h00, 1, 0)});
    dirs.push_back({mk({8'h07, 8'h13, 8'h00, 8'h01}, 4'b1111, 1, 1, 1), mke(8'hFF, 8'h00, 8'hFF, 1, 1)});
`ifdef JTCOP_MIX_SHADOW_EN
    dirs.push_back({mk({8'h00, 8'h13, 8'h00, 8'h01}, 4'b1111, 1, 1, 1), mke(8'h7F, 8'h2A, 8'h55, 1, 1)});
`endif
    for (int i = 0; i < dirs.size(); i++) tick($sformatf("dir%0d", i), dirs[i].v, dirs[i].e, 1);

    // collision: CPU write on the same edge the video port reads 0x213
    tick("coll.pix", t2, model(t2), 1);
    tick("coll.f1", blank, model(blank), 1);
    tick("coll.f2", blank, model(blank), 1);
    bus.cpu_addr = 10'h213; bus.cpu_dout = 16'h0FFF; bus.cpu_dsn = 2'b00;
    bus.pal_cs = 1; bus.cpu_rnw = 0;
    tick("coll.f3", blank, model(blank), 1);
    bus.pal_cs = 0; bus.cpu_rnw = 1; bus.cpu_dsn = 2'b11;
    pal_m[10'h213] = 16'h0FFF;
    tick("coll.new", t2, mke(8'hFF, 8'hFF, 8'hFF, 1, 1), 1);
    for (int i = 0; i < 4; i++) tick("coll.drain", blank, model(blank), 1);

    // random stream with pxl_cen gaps
    for (int i = 0; i < 300; i++) begin
      v = rnd_vec();
      if ($urandom_range(3, 0) == 0) tick("rnd.hold", v, model(v), 0);
      else                           tick($sformatf("rnd%0d", i), v, model(v), 1);
    end

    // reset mid-line, then keep streaming
    do_reset("reset_mid");
    for (int i = 0; i < 200; i++) begin
      v = rnd_vec();
      if ($urandom_range(3, 0) == 0) tick("rnd2.hold", v, model(v), 0);
      else                           tick($sformatf("rnd2_%0d", i), v, model(v), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
